// File: rtl/interp_ratio.sv
// Power-of-two interpolator: each accepted sample opens a segment of R = 2^k output cycles.
// The output ramps linearly from the previous sample to the new one, or holds flat in zero-order-hold mode.
module interp_ratio #(
    parameter int IN_W       = 15,
    parameter int OUT_W      = 16,
    parameter int LOG2_R_MAX = 6
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [$clog2(LOG2_R_MAX+1)-1:0]    log2_r,
    input  logic                               mode,
    input  logic signed [IN_W-1:0]             in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic signed [OUT_W-1:0]            out_data,
    output logic                               out_valid,
    output logic                               underrun
);

    localparam int KW = $clog2(LOG2_R_MAX+1);
    localparam int F  = LOG2_R_MAX;
    localparam int AW = IN_W + F;
    localparam int SW = IN_W + 1 + F;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_next;
    logic [LOG2_R_MAX-1:0]   cnt, cnt_last;
    logic [KW-1:0]           k, k_sel;
    logic                    mode_q;
    logic signed [IN_W-1:0]  v, v_prev;
    logic signed [AW-1:0]    acc;
    logic signed [IN_W:0]    diff;
    logic signed [SW-1:0]    diff_scaled, step;
    logic                    boundary, transfer;

    // The step is derived from v/v_prev so that it is exact and needs no separate register.
    always_comb begin
        k_sel       = (log2_r > KW'(LOG2_R_MAX)) ? KW'(LOG2_R_MAX) : log2_r;
        cnt_last    = ~({LOG2_R_MAX{1'b1}} << k);
        boundary    = (cnt == cnt_last);
        in_ready    = (state == IDLE) || boundary;
        transfer    = in_valid && in_ready;
        out_valid   = (state == RUN);
        out_data    = acc[AW-1 -: OUT_W];
        diff        = {v[IN_W-1], v} - {v_prev[IN_W-1], v_prev};
        diff_scaled = {diff, {F{1'b0}}};
        step        = '0;
        if (!mode_q) begin
            step = diff_scaled >>> k;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (transfer) state_next = RUN;
            RUN:  state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            k        <= '0;
            mode_q   <= 1'b0;
            v        <= '0;
            v_prev   <= '0;
            acc      <= '0;
            underrun <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                v      <= in_data;
                v_prev <= in_data;
                acc    <= {in_data, {F{1'b0}}};
                cnt    <= '0;
                k      <= k_sel;
                mode_q <= mode;
            end
        end else if (boundary) begin
            // A missing sample repeats v, so the next segment is flat.
            v_prev <= v;
            if (in_valid) begin
                v <= in_data;
            end else begin
                underrun <= 1'b1;
            end
            acc    <= {v, {F{1'b0}}};
            cnt    <= '0;
            k      <= k_sel;
            mode_q <= mode;
        end else begin
            acc <= AW'(acc + step);
            cnt <= cnt + LOG2_R_MAX'(1);
        end
    end

endmodule

// File: tb/tb_interp_ratio.sv
// Self-checking bench for interp_ratio: a per-cycle reference model feeds a scoreboard queue,
// plus a table of directed ramp vectors and hand-written underrun / ratio-change / reset sequences.
module tb_interp_ratio;

    localparam int IN_W  = 15;
    localparam int OUT_W = 16;
    localparam int LMAX  = 6;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [2:0]              log2_r;
    logic                    mode;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    underrun;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    interp_ratio #(.IN_W(IN_W), .OUT_W(OUT_W), .LOG2_R_MAX(LMAX)) dut (
        .clock     (clock),
        .reset     (reset),
        .log2_r    (log2_r),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    typedef struct {
        int valid;
        int data;
        int ready;
        int under;
    } exp_t;

    exp_t sb[$];

    // Reference state: a segment is described by its start/end values and the phase within it.
    int m_run, m_cnt, m_k, m_mode, m_start, m_end, m_v, m_under;

    function automatic int fdiv(int a, int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int kclamp(int kk);
        return (kk > LMAX) ? LMAX : kk;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   r;
        r       = 1 << m_k;
        e.valid = m_run;
        e.data  = fdiv((m_start * r + (m_end - m_start) * m_cnt) * (1 << (OUT_W - IN_W)), r);
        e.ready = (!m_run || m_cnt == r - 1) ? 1 : 0;
        e.under = m_under;
        return e;
    endfunction

    task automatic model_step();
        int r, nv, x;
        r = 1 << m_k;
        x = int'(in_data);
        if (reset) begin
            m_run = 0; m_cnt = 0; m_k = 0; m_mode = 0;
            m_start = 0; m_end = 0; m_v = 0; m_under = 0;
        end else if (m_run == 0) begin
            if (in_valid) begin
                m_run = 1; m_cnt = 0; m_start = x; m_end = x; m_v = x;
                m_k = kclamp(int'(log2_r)); m_mode = int'(mode);
            end
        end else if (m_cnt == r - 1) begin
            nv = in_valid ? x : m_v;
            if (!in_valid) m_under = 1;
            m_mode  = int'(mode);
            m_k     = kclamp(int'(log2_r));
            m_start = m_v;
            m_end   = m_mode ? m_v : nv;
            m_v     = nv;
            m_cnt   = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic checkOutput(string name, int act, int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        sb.push_back(model_out());
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checkOutput("out_valid", int'(out_valid), e.valid);
        checkOutput("out_data",  int'(out_data),  e.data);
        checkOutput("in_ready",  int'(in_ready),  e.ready);
        checkOutput("underrun",  int'(underrun),  e.under);
    endtask

    task automatic applyStimulus(input int rst, input int vld, input int x, input int kk, input int md);
        reset    = rst[0];
        in_valid = vld[0];
        in_data  = IN_W'(x);
        log2_r   = 3'(kk);
        mode     = md[0];
    endtask

    typedef struct {
        int k;
        int md;
        int s0;
        int s1;
        int n;
        int e[9];
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r, cnt;

        vecs[0] = '{3, 0, 0, 800, 9, '{0, 200, 400, 600, 800, 1000, 1200, 1400, 1600}};
        vecs[1] = '{2, 0, -7, 0, 5, '{-14, -11, -7, -4, 0, 0, 0, 0, 0}};
        vecs[2] = '{3, 1, 100, 300, 9, '{200, 200, 200, 200, 200, 200, 200, 200, 600}};
        vecs[3] = '{1, 0, 10, 13, 3, '{20, 23, 26, 0, 0, 0, 0, 0, 0}};
        vecs[4] = '{0, 0, 5, -3, 2, '{10, -6, 0, 0, 0, 0, 0, 0, 0}};
        vecs[5] = '{6, 0, -16384, 16383, 9,
                    '{-32768, -31745, -30721, -29697, -28673, -27649, -26625, -25601, -24577}};
        vecs[6] = '{7, 0, 0, 64, 9, '{0, 2, 4, 6, 8, 10, 12, 14, 16}};

        applyStimulus(1, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            tick();
            applyStimulus(0, 1, vecs[i].s0, vecs[i].k, vecs[i].md);
            tick();
            applyStimulus(0, 1, vecs[i].s1, vecs[i].k, vecs[i].md);
            r = 1 << kclamp(vecs[i].k);
            repeat (r - 1) tick();
            for (int j = 0; j < vecs[i].n; j++) begin
                tick();
                checkOutput($sformatf("vec%0d[%0d]", i, j), int'(out_data), vecs[i].e[j]);
            end
        end

        // Underrun: one boundary with no sample gives a flat segment and a sticky flag.
        applyStimulus(1, 0, 0, 2, 0);
        tick();
        applyStimulus(0, 1, 40, 2, 0);
        tick();
        applyStimulus(0, 1, 80, 2, 0);
        repeat (4) tick();
        repeat (3) tick();
        applyStimulus(0, 0, 80, 2, 0);
        tick();
        checkOutput("underrun_rise", int'(underrun), 1);
        repeat (3) begin
            tick();
            checkOutput("underrun_flat", int'(out_data), 160);
        end
        applyStimulus(0, 1, 0, 2, 0);
        repeat (2) tick();
        checkOutput("ramp_resume", int'(out_data), 120);
        repeat (6) tick();
        checkOutput("underrun_sticky", int'(underrun), 1);

        // Reset mid-ramp with a simultaneous valid sample wins and drops the sample.
        applyStimulus(1, 1, 500, 2, 0);
        tick();
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_underrun", int'(underrun), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        applyStimulus(0, 0, 500, 2, 0);
        tick();
        checkOutput("rst_not_accepted", int'(out_valid), 0);

        // Ratio change mid-segment applies from the next segment.
        applyStimulus(0, 1, 10, 3, 0);
        tick();
        applyStimulus(0, 1, 30, 1, 0);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            tick();
            cnt = cnt + 1;
        end
        checkOutput("seg_len_k3", cnt, 7);
        tick();
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            tick();
            cnt = cnt + 1;
        end
        checkOutput("seg_len_k1", cnt, 1);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
